// File: rtl/alu_pkg.sv
// Shared definitions for the operand loader: FSM state encoding and defaults.
package alu_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  // Counter width covers the full legal DEBOUNCE_CYCLES range (2..65535).
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    PENDING = 2'b10,
    ILLEGAL = 2'b11
  } ld_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and press pulse.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   btn_raw : raw asynchronous, bouncing button
//   press   : one-cycle pulse, high the cycle after the debounced level rises
module btn_debounce
  import alu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             differ_c;
  logic             accept_c;

  assign differ_c = sync2 ^ level;
  assign accept_c = differ_c && (cnt == CNT_LAST);

  // The pulse is registered on the same edge the level rises, so it is
  // visible during the following cycle and never on a release.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (!differ_c || accept_c) cnt <= '0;
      else                       cnt <= cnt + CNT_W'(1);
      if (accept_c) level <= sync2;
      press <= accept_c & sync2;
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Loads two ALU operands from switches on successive debounced button presses
// and holds the pair until the downstream stage accepts it.
//   clk, rst  : clock, synchronous active-high reset
//   btn_load  : raw load button
//   sw_data   : operand value from switches
//   op_ready  : downstream accepts the pair (only meaningful in PENDING)
//   reg_a/b   : captured operands
//   op_valid  : pair complete (state is PENDING)
//   state_o   : current state encoding
//   overrun   : sticky, press arrived while a pair was pending
module operand_loader
  import alu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned W               = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_load,
  input  logic [W-1:0] sw_data,
  input  logic         op_ready,
  output logic [W-1:0] reg_a,
  output logic [W-1:0] reg_b,
  output logic         op_valid,
  output logic [1:0]   state_o,
  output logic         overrun
);

  ld_state_e    state_q;
  ld_state_e    state_d;
  logic [W-1:0] reg_a_d;
  logic [W-1:0] reg_b_d;
  logic         op_valid_d;
  logic         overrun_d;
  logic         press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_load),
    .press  (press)
  );

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_A;
      reg_a    <= '0;
      reg_b    <= '0;
      op_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      reg_a    <= reg_a_d;
      reg_b    <= reg_b_d;
      op_valid <= op_valid_d;
      overrun  <= overrun_d;
    end
  end

  // Next state and operand updates; op_ready matters only in PENDING, where
  // a handshake always wins over a coincident press.
  always_comb begin
    state_d   = state_q;
    reg_a_d   = reg_a;
    reg_b_d   = reg_b;
    overrun_d = overrun;
    case (state_q)
      WAIT_A: begin
        if (press) begin
          reg_a_d = sw_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press) begin
          reg_b_d = sw_data;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (op_ready) begin
          state_d   = WAIT_A;
          overrun_d = 1'b0;
        end else if (press) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = WAIT_A;
    endcase
    op_valid_d = (state_d == PENDING);
  end

  assign state_o = state_q;

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples needed to accept a button level change; legal range 2..65535.
REQ-002 Parameter W, default 8: operand width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_load  input  1  raw, asynchronous, bouncing load push-button.
REQ-006 sw_data  input  W  operand value from switches, sampled on an accepted press.
REQ-007 op_ready  input  1  downstream ALU stage accepts the operand pair.
REQ-008 reg_a  output  W  captured operand A.
REQ-009 reg_b  output  W  captured operand B.
REQ-010 op_valid  output  1  operand pair complete and held stable.
REQ-011 state_o  output  2  current FSM state encoding, for status LEDs.
REQ-012 overrun  output  1  sticky flag: press arrived while a pair was pending.

Function
REQ-013 btn_load SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce counter SHALL increment each cycle the synchronized level differs from the debounced level, and clear to 0 on any cycle they match.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level SHALL take the synchronized value on the next edge and the counter SHALL clear.
REQ-016 A press pulse SHALL be one cycle wide, asserted on the cycle after the debounced level rises 0->1; a release SHALL produce no pulse.
REQ-017 From the first rising edge that samples btn_load high (held clean), the target register SHALL update on rising edge DEBOUNCE_CYCLES+3.
REQ-018 The FSM SHALL have states WAIT_A=2'b00, WAIT_B=2'b01, PENDING=2'b10; 2'b11 is illegal and SHALL recover to WAIT_A on the next edge.
REQ-019 WAIT_A with press: reg_a <= sw_data, next state WAIT_B.
REQ-020 WAIT_B with press: reg_b <= sw_data, next state PENDING.
REQ-021 op_valid SHALL be 1 exactly when the state is PENDING; reg_a and reg_b SHALL NOT change while it is 1.
REQ-022 PENDING with op_ready=1: handshake completes on that edge, next state WAIT_A, overrun cleared.
REQ-023 PENDING with press and op_ready=0: press discarded, overrun set to 1.
REQ-024 PENDING with press and op_ready=1 on the same edge: handshake completes, press discarded, overrun SHALL end at 0.
REQ-025 op_ready SHALL be ignored in WAIT_A and WAIT_B.
REQ-026 A bounce shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse and no state change.
REQ-027 Holding the button SHALL produce exactly one pulse per press.

Reset
REQ-028 While rst=1 on an edge: state WAIT_A, reg_a=0, reg_b=0, op_valid=0, overrun=0, debounced level=0, counter=0, synchronizer flops=0.
REQ-029 Reset mid-operation (any state, any counter value) SHALL abandon any partially loaded pair.
REQ-030 A button held through reset release SHALL produce one pulse after DEBOUNCE_CYCLES+3 edges.

Structure
REQ-031 The FSM state enum and the DEBOUNCE_CYCLES default SHALL live in a shared package, alu_pkg.
REQ-032 Synchronizer, debounce counter and press-pulse logic SHALL be one sub-module, btn_debounce, with ports clk, rst, btn_raw and press.
REQ-033 operand_loader SHALL instantiate btn_debounce once and hold only the FSM and the operand registers.

Verification (sim DEBOUNCE_CYCLES=4)
REQ-034 Clean press, sw_data=8'h3C, held 10 cycles -> reg_a=8'h3C at edge 7, state_o=01, no second capture.
REQ-035 Two presses, 8'hF0 then 8'h0F, op_ready=0 -> op_valid=1, reg_a=F0, reg_b=0F, both held 20 cycles; then op_ready=1 for one cycle -> state_o=00, op_valid=0.
REQ-036 Glitch trains of 1-, 2- and 3-cycle high pulses in WAIT_A -> state_o stays 00, reg_a unchanged.
REQ-037 Third press in PENDING with op_ready=0 -> overrun=1, reg_b unchanged; op_ready=1 -> overrun=0, state 00.
REQ-038 rst=1 asserted in WAIT_B, reg_a=8'hAA -> next edge: all outputs 0, state_o=00.
REQ-039 Press pulse coincident with op_ready=1 in PENDING -> state 00, overrun=0, reg_a not loaded.
